// File: rtl/lot_counter_bcd_pkg.sv
// Shared constants and BCD helper functions for the lot counter.
// Helpers take the widest supported total and a live digit count.
package lot_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 6;
  localparam int MAX_W = BCD_W * MAX_DIGITS;

  // The most significant differing digit decides; equal totals count as a match.
  function automatic logic bcd_ge(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input int n);
    logic decided;
    logic result;
    decided = 1'b0;
    result = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if ((i < n) && !decided) begin
        if (a[BCD_W*i +: BCD_W] > b[BCD_W*i +: BCD_W]) begin
          result = 1'b1;
          decided = 1'b1;
        end else if (a[BCD_W*i +: BCD_W] < b[BCD_W*i +: BCD_W]) begin
          result = 1'b0;
          decided = 1'b1;
        end else begin
          decided = 1'b0;
        end
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic logic bcd_valid(input logic [MAX_W-1:0] v, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && (v[BCD_W*i +: BCD_W] > BCD_MAX)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/lot_counter_bcd_digit.sv
// One decade of the completed-group total. The carry is combinational so a
// whole chain of digits advances on the same edge.
module bcd_digit import lot_counter_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic       sat,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc & (q == BCD_MAX);

  // Decade register: clear wins, sat pins a digit that is already at 9.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 4'd0;
    end else if (clear) begin
      q <= 4'd0;
    end else if (inc && !sat) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/lot_counter_bcd.sv
// Item/group counter with a BCD total of completed groups, target detection,
// optional stop-at-target and wrap or saturate on total overflow.
module lot_counter_bcd import lot_counter_pkg::*; #(
  parameter int GROUP_SIZE     = 12,
  parameter int NUM_DIGITS     = 2,
  parameter int WRAP_MODE      = 1,
  parameter int STOP_AT_TARGET = 0,
  parameter int EDGE_DETECT    = 1,
  localparam int ITEM_W = (GROUP_SIZE > 2) ? $clog2(GROUP_SIZE) : 1,
  localparam int TOT_W  = BCD_W * NUM_DIGITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              item_in,
  input  logic              enable,
  input  logic              clear,
  input  logic [TOT_W-1:0]  target_bcd,
  output logic [ITEM_W-1:0] items_in_group,
  output logic [TOT_W-1:0]  groups_bcd,
  output logic              group_done,
  output logic              target_reached,
  output logic              overflow
);

  logic prev_item_r;
  logic edge_s;
  logic ev_s;
  logic last_item_s;
  logic complete_s;
  logic wrap_evt_s;
  logic sat_s;
  logic target_ok_s;
  logic inc_s [NUM_DIGITS+1];
  logic [TOT_W-1:0] groups_next_s;

  assign edge_s      = (EDGE_DETECT != 0) ? (item_in & ~prev_item_r) : item_in;
  assign ev_s        = enable & edge_s & ~((STOP_AT_TARGET != 0) & target_reached);
  assign last_item_s = (items_in_group == ITEM_W'(GROUP_SIZE - 1));
  assign complete_s  = ev_s & last_item_s & ~clear;

  // Carry out of the top digit on a completion means the total was all 9s.
  assign inc_s[0]    = complete_s;
  assign wrap_evt_s  = inc_s[NUM_DIGITS];
  assign sat_s       = (WRAP_MODE == 0) & wrap_evt_s;
  assign target_ok_s = (target_bcd != TOT_W'(0)) && bcd_valid(MAX_W'(target_bcd), NUM_DIGITS);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (inc_s[k]),
      .sat   (sat_s),
      .q     (groups_bcd[BCD_W*k +: BCD_W]),
      .carry (inc_s[k+1])
    );
  end

  // Look-ahead of the total so target_reached rises on the same edge as the total.
  always_comb begin
    groups_next_s = groups_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (inc_s[k] && !sat_s) begin
        groups_next_s[BCD_W*k +: BCD_W] = (groups_bcd[BCD_W*k +: BCD_W] == BCD_MAX) ?
                                          4'd0 : groups_bcd[BCD_W*k +: BCD_W] + 4'd1;
      end else begin
        groups_next_s[BCD_W*k +: BCD_W] = groups_bcd[BCD_W*k +: BCD_W];
      end
    end
  end

  // Edge history keeps tracking item_in while disabled, so stale edges are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_item_r <= 1'b1;
    end else begin
      prev_item_r <= item_in;
    end
  end

  // Item counter, completion pulse, target level and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      items_in_group <= ITEM_W'(0);
      group_done     <= 1'b0;
      target_reached <= 1'b0;
      overflow       <= 1'b0;
    end else if (clear) begin
      items_in_group <= ITEM_W'(0);
      group_done     <= 1'b0;
      target_reached <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (ev_s) begin
        items_in_group <= last_item_s ? ITEM_W'(0) : items_in_group + ITEM_W'(1);
      end else begin
        items_in_group <= items_in_group;
      end
      group_done     <= complete_s;
      target_reached <= target_ok_s & bcd_ge(MAX_W'(groups_next_s), MAX_W'(target_bcd), NUM_DIGITS);
      overflow       <= overflow | wrap_evt_s;
    end
  end

endmodule
